// File: rtl/controller_sequencer_pkg.sv
// Shared constants for the SAP-1 control unit.
// Contents: opcodes, ring-slot indices, the sequencer mode encoding and the inactive control word.
package controller_sequencer_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Bit positions of each timing state in the one-hot ring vector.
  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int T4_IDX = 3;
  localparam int T5_IDX = 4;
  localparam int T6_IDX = 5;

  // Coarse mode. The T1..T6 sub-state lives in the ring counter.
  typedef enum logic [1:0] {
    MODE_RESET = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_HALT  = 2'd2
  } mode_e;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_word_t;

  // Active-low strobes sit at 1 and active-high strobes sit at 0.
  localparam ctrl_word_t CTRL_INACTIVE = '{
    cp: 1'b0, ep: 1'b0, lm: 1'b1, ce: 1'b1, li: 1'b1, ei: 1'b1,
    la: 1'b1, ea: 1'b0, su: 1'b0, eu: 1'b0, lb: 1'b1, lo: 1'b1
  };

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// Six-slot one-hot timing ring for the SAP-1 sequencer.
// Clr empties the ring. The first free-running edge after that loads T1. Hold freezes the current value.
module ring_counter (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Hold,
  output logic [5:0] T
);

  // Rotate the one-hot token once per edge. An empty ring restarts at T1.
  always_ff @(posedge Clk) begin
    if (Clr)
      T <= '0;
    else if (!Hold) begin
      if (T == 6'b000000)
        T <= 6'b000001;
      else
        T <= {T[4:0], T[5]};
    end
  end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: the mode FSM and ring counter drive a combinational decoder.
// The decoder turns the ring slot and the opcode into the per-cycle control word.
//
// state      | meaning
// -----------+---------------------------------------------------------
// MODE_RESET | Clr seen. Ring empty, outputs inactive, Hlt=0.
// MODE_RUN   | Fetch/execute. Ring walks T1..T6 and the decoder is active.
// MODE_HALT  | HLT executed. Ring empty and frozen, Hlt=1, wait for Clr.
module controller_sequencer (
  input  logic       Clk,
  input  logic       Clr,
  input  logic [3:0] Opcode,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm,
  output logic       CE,
  output logic       Li,
  output logic       Ei,
  output logic       La,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb,
  output logic       Lo,
  output logic       Hlt,
  output logic [5:0] T
);
  import controller_sequencer_pkg::*;

  mode_e      mode, mode_next;
  logic [5:0] t_ring;
  logic       hlt_t4;
  logic       ring_clr;
  logic       ring_hold;
  ctrl_word_t cw;

  assign hlt_t4    = t_ring[T4_IDX] && (Opcode == OP_HLT);
  // Emptying the ring on the HLT edge makes T read zero from HALT onward.
  assign ring_clr  = Clr || hlt_t4;
  assign ring_hold = (mode == MODE_HALT);

  ring_counter u_ring (
    .Clk  (Clk),
    .Clr  (ring_clr),
    .Hold (ring_hold),
    .T    (t_ring)
  );

  // Mode register. Clr wins over every mode, including HALT.
  always_ff @(posedge Clk) begin
    if (Clr)
      mode <= MODE_RESET;
    else
      mode <= mode_next;
  end

  // Next mode: leave RESET on the first free edge, then stick in HALT after HLT.
  always_comb begin
    mode_next = mode;
    case (mode)
      MODE_RESET: mode_next = MODE_RUN;
      MODE_RUN:   if (hlt_t4) mode_next = MODE_HALT;
      MODE_HALT:  mode_next = MODE_HALT;
      default:    mode_next = MODE_RESET;
    endcase
  end

  // Control-word decode from the ring slot and the opcode.
  always_comb begin
    cw  = CTRL_INACTIVE;
    Hlt = (mode == MODE_HALT);
    if (mode == MODE_RUN) begin
      if (t_ring[T1_IDX]) begin
        cw.ep = 1'b1;
        cw.lm = 1'b0;
      end else if (t_ring[T2_IDX]) begin
        cw.cp = 1'b1;
      end else if (t_ring[T3_IDX]) begin
        cw.ce = 1'b0;
        cw.li = 1'b0;
      end else if (t_ring[T4_IDX]) begin
        case (Opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw.ei = 1'b0;
            cw.lm = 1'b0;
          end
          OP_OUT: begin
            cw.ea = 1'b1;
            cw.lo = 1'b0;
          end
          OP_HLT:  Hlt = 1'b1;
          default: ;
        endcase
      end else if (t_ring[T5_IDX]) begin
        case (Opcode)
          OP_LDA: begin
            cw.ce = 1'b0;
            cw.la = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            cw.ce = 1'b0;
            cw.lb = 1'b0;
          end
          default: ;
        endcase
      end else if (t_ring[T6_IDX]) begin
        if (Opcode == OP_ADD || Opcode == OP_SUB) begin
          cw.eu = 1'b1;
          cw.la = 1'b0;
          cw.su = (Opcode == OP_SUB);
        end
      end
    end
  end

  assign Cp = cw.cp;
  assign Ep = cw.ep;
  assign Lm = cw.lm;
  assign CE = cw.ce;
  assign Li = cw.li;
  assign Ei = cw.ei;
  assign La = cw.la;
  assign Ea = cw.ea;
  assign Su = cw.su;
  assign Eu = cw.eu;
  assign Lb = cw.lb;
  assign Lo = cw.lo;
  assign T  = t_ring;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer.
// A phase-number model (0=RESET, 1..6=T1..T6, 7=HALT) is checked against the DUT on every negedge.
// Directed steps add literal expectations at chosen points in the run.
module tb_controller_sequencer;

  logic       Clk = 1'b0;
  logic       Clr = 1'b1;
  logic [3:0] Opcode = 4'b0000;
  logic Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Hlt;
  logic [5:0] T;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  ph = 0;
  bit  armed = 1'b0;

  controller_sequencer dut (
    .Clk(Clk), .Clr(Clr), .Opcode(Opcode),
    .Cp(Cp), .Ep(Ep), .Lm(Lm), .CE(CE), .Li(Li), .Ei(Ei),
    .La(La), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo),
    .Hlt(Hlt), .T(T)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t, phase=%0d)", name, act, exp, $time, ph);
    end
  endtask

  // Expected {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo,Hlt} for a phase and opcode.
  function automatic logic [12:0] model_out(input int p, input logic [3:0] op);
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hl;
    bit alu;
    cp = 0; ep = 0; lm = 1; ce = 1; li = 1; ei = 1;
    la = 1; ea = 0; su = 0; eu = 0; lb = 1; lo = 1; hl = 0;
    alu = (op == 4'b0001) || (op == 4'b0010);
    case (p)
      1: begin ep = 1; lm = 0; end
      2: cp = 1;
      3: begin ce = 0; li = 0; end
      4: begin
        if (op == 4'b0000 || alu) begin ei = 0; lm = 0; end
        else if (op == 4'b1110) begin ea = 1; lo = 0; end
        else if (op == 4'b1111) hl = 1;
      end
      5: begin
        if (op == 4'b0000) begin ce = 0; la = 0; end
        else if (alu) begin ce = 0; lb = 0; end
      end
      6: if (alu) begin eu = 1; la = 0; su = (op == 4'b0010); end
      7: hl = 1;
      default: ;
    endcase
    return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hl};
  endfunction

  function automatic logic [5:0] model_t(input int p);
    logic [5:0] one;
    one = 6'b000001;
    return (p >= 1 && p <= 6) ? (one << (p - 1)) : 6'b000000;
  endfunction

  function automatic int model_next(input int p, input logic clr, input logic [3:0] op);
    if (clr) return 0;
    case (p)
      0: return 1;
      4: return (op == 4'b1111) ? 7 : 5;
      6: return 1;
      7: return 7;
      default: return p + 1;
    endcase
  endfunction

  // Advance the model on every edge, using the inputs the DUT sees.
  always @(posedge Clk) begin
    ph    <= model_next(ph, Clr, Opcode);
    armed <= 1'b1;
  end

  // Per-cycle compare of every output, plus the single-bus-driver rule.
  always @(negedge Clk) begin
    if (armed) begin
      int drivers;
      check("ctrl_word", {19'd0, Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Hlt},
            {19'd0, model_out(ph, Opcode)});
      check("T_vector", {26'd0, T}, {26'd0, model_t(ph)});
      drivers = int'(Ep) + int'(!CE) + int'(!Ei) + int'(Ea) + int'(Eu);
      check("one_bus_driver", {31'd0, drivers <= 1}, 32'd1);
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    logic [3:0] mix [4];
    mix[0] = 4'b1110; mix[1] = 4'b0001; mix[2] = 4'b0111; mix[3] = 4'b0000;

    // Reset held for three edges.
    Clr = 1'b1;
    repeat (3) step();
    check("rst_T", {26'd0, T}, 32'h0);
    check("rst_Hlt", {31'd0, Hlt}, 32'h0);
    check("rst_Lm", {31'd0, Lm}, 32'h1);
    check("rst_Ep", {31'd0, Ep}, 32'h0);

    // Release: T1 one edge later.
    Clr = 1'b0;
    Opcode = 4'b0000;
    step();
    check("t1_T", {26'd0, T}, 32'h01);
    check("t1_Ep", {31'd0, Ep}, 32'h1);
    check("t1_Lm", {31'd0, Lm}, 32'h0);

    // LDA.
    step(); step(); step();
    check("lda_t4_Ei", {31'd0, Ei}, 32'h0);
    check("lda_t4_Lm", {31'd0, Lm}, 32'h0);
    step();
    check("lda_t5_CE", {31'd0, CE}, 32'h0);
    check("lda_t5_La", {31'd0, La}, 32'h0);
    step();
    check("lda_t6_La", {31'd0, La}, 32'h1);
    check("lda_t6_T", {26'd0, T}, 32'h20);
    step();
    check("lda_back_T1", {26'd0, T}, 32'h01);

    // SUB.
    Opcode = 4'b0010;
    step(); step(); step(); step();
    check("sub_t5_Lb", {31'd0, Lb}, 32'h0);
    check("sub_t5_Su", {31'd0, Su}, 32'h0);
    step();
    check("sub_t6_Eu", {31'd0, Eu}, 32'h1);
    check("sub_t6_La", {31'd0, La}, 32'h0);
    check("sub_t6_Su", {31'd0, Su}, 32'h1);
    step();
    check("sub_back_T1", {26'd0, T}, 32'h01);

    // Mixed opcodes, 24 cycles. The compare process checks the bus rule each cycle.
    for (int i = 0; i < 4; i++) begin
      Opcode = mix[i];
      step(); step(); step();
      if (i == 0) begin
        check("out_t4_Ea", {31'd0, Ea}, 32'h1);
        check("out_t4_Lo", {31'd0, Lo}, 32'h0);
      end
      if (i == 2) begin
        check("nop_t4_Ei", {31'd0, Ei}, 32'h1);
        check("nop_t4_Lm", {31'd0, Lm}, 32'h1);
      end
      step(); step(); step();
      check("mix_back_T1", {26'd0, T}, 32'h01);
    end

    // ADD interrupted by Clr in T5.
    Opcode = 4'b0001;
    step(); step(); step(); step();
    check("add_t5_Lb", {31'd0, Lb}, 32'h0);
    Clr = 1'b1;
    step();
    check("abort_La", {31'd0, La}, 32'h1);
    check("abort_Lb", {31'd0, Lb}, 32'h1);
    check("abort_T", {26'd0, T}, 32'h0);
    Clr = 1'b0;
    step();
    check("abort_restart_T1", {26'd0, T}, 32'h01);

    // HLT.
    Opcode = 4'b1111;
    step(); step(); step();
    check("hlt_t4_Hlt", {31'd0, Hlt}, 32'h1);
    check("hlt_t4_T", {26'd0, T}, 32'h08);
    step();
    check("halt_T", {26'd0, T}, 32'h0);
    check("halt_Hlt", {31'd0, Hlt}, 32'h1);
    Opcode = 4'b0000;
    repeat (10) step();
    check("halt_held_T", {26'd0, T}, 32'h0);
    check("halt_held_Hlt", {31'd0, Hlt}, 32'h1);
    Clr = 1'b1;
    step();
    check("halt_clr_Hlt", {31'd0, Hlt}, 32'h0);
    Clr = 1'b0;
    step();
    check("halt_restart_T1", {26'd0, T}, 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
